// File: rtl/micro_seq.sv
// Microprogrammed sequencer for the multi-cycle MIPS datapath: a 4-bit uPC
// walks a 12-word control ROM with sequential, dispatch and fetch addressing.
module micro_seq #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic             mem_rdy,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IRWr,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWr,
    output logic             RegDst,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       upc,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt
);

    // state | meaning
    // 0  FETCH   | read instruction, PC += 4
    // 1  DECODE  | register read, branch target, dispatch on Op
    // 2  MEMADDR | effective address for lw/sw
    // 3  MEMRD   | data memory read
    // 4  MEMWB   | load writeback
    // 5  MEMWR   | data memory write
    // 6  REXEC   | R-type ALU operation
    // 7  RWB     | R-type writeback
    // 8  BEQ     | compare and conditional branch
    // 9  JUMP    | jump
    // 10 ADDIEX  | addi ALU operation
    // 11 ADDIWB  | addi writeback
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADDR = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_REXEC   = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BEQ     = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;

    localparam logic [1:0] NX_SEQ   = 2'd0;
    localparam logic [1:0] NX_DISP1 = 2'd1;
    localparam logic [1:0] NX_DISP2 = 2'd2;
    localparam logic [1:0] NX_FETCH = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [3:0]       r_upc;
    logic [CNT_W-1:0] r_inst_cnt;

    logic       w_pcwr, w_pcwrcond, w_iord, w_memrd, w_memwr, w_irwr;
    logic       w_memtoreg, w_alusrca, w_regwr, w_regdst;
    logic [1:0] w_pcsrc, w_aluop, w_alusrcb, w_nx;
    logic [3:0] w_disp1, w_disp2, w_upc_next;
    logic       w_op_ok, w_stall, w_retire;

    always_comb begin
        w_pcwr     = 1'b0;
        w_pcwrcond = 1'b0;
        w_iord     = 1'b0;
        w_memrd    = 1'b0;
        w_memwr    = 1'b0;
        w_irwr     = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_regwr    = 1'b0;
        w_regdst   = 1'b0;
        w_pcsrc    = 2'b00;
        w_aluop    = 2'b00;
        w_alusrcb  = 2'b00;
        w_nx       = NX_FETCH;
        case (r_upc)
            S_FETCH: begin
                w_memrd = 1'b1; w_irwr = 1'b1; w_pcwr = 1'b1;
                w_alusrcb = 2'b01; w_nx = NX_SEQ;
            end
            S_DECODE:  begin w_alusrcb = 2'b11; w_nx = NX_DISP1; end
            S_MEMADDR: begin w_alusrca = 1'b1; w_alusrcb = 2'b10; w_nx = NX_DISP2; end
            S_MEMRD:   begin w_memrd = 1'b1; w_iord = 1'b1; w_nx = NX_SEQ; end
            S_MEMWB:   begin w_memtoreg = 1'b1; w_regwr = 1'b1; end
            S_MEMWR:   begin w_memwr = 1'b1; w_iord = 1'b1; end
            S_REXEC:   begin w_alusrca = 1'b1; w_aluop = 2'b10; w_nx = NX_SEQ; end
            S_RWB:     begin w_regdst = 1'b1; w_regwr = 1'b1; end
            S_BEQ: begin
                w_alusrca = 1'b1; w_aluop = 2'b01;
                w_pcwrcond = 1'b1; w_pcsrc = 2'b01;
            end
            S_JUMP:    begin w_pcwr = 1'b1; w_pcsrc = 2'b10; end
            S_ADDIEX:  begin w_alusrca = 1'b1; w_alusrcb = 2'b10; w_nx = NX_SEQ; end
            S_ADDIWB:  begin w_regwr = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        w_disp1 = S_FETCH;
        w_op_ok = 1'b1;
        case (Op)
            6'b000000: w_disp1 = S_REXEC;
            6'b100011: w_disp1 = S_MEMADDR;
            6'b101011: w_disp1 = S_MEMADDR;
            6'b000100: w_disp1 = S_BEQ;
            6'b000010: w_disp1 = S_JUMP;
            6'b001000: w_disp1 = S_ADDIEX;
            default:   w_op_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_disp2 = S_FETCH;
        case (Op)
            6'b100011: w_disp2 = S_MEMRD;
            6'b101011: w_disp2 = S_MEMWR;
            default:   w_disp2 = S_FETCH;
        endcase
    end

    // Only the memory-touching states wait on mem_rdy.
    assign w_stall = ((r_upc == S_FETCH) || (r_upc == S_MEMRD) || (r_upc == S_MEMWR))
                     && !mem_rdy;

    always_comb begin
        w_upc_next = r_upc;
        if (!w_stall) begin
            case (w_nx)
                NX_SEQ:   w_upc_next = r_upc + 4'd1;
                NX_DISP1: w_upc_next = w_disp1;
                NX_DISP2: w_upc_next = w_disp2;
                default:  w_upc_next = S_FETCH;
            endcase
        end
    end

    assign w_retire = !w_stall && (w_nx == NX_FETCH) &&
                      ((r_upc == S_MEMWB) || (r_upc == S_MEMWR) || (r_upc == S_RWB) ||
                       (r_upc == S_BEQ)   || (r_upc == S_JUMP)  || (r_upc == S_ADDIWB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc      <= S_FETCH;
            r_inst_cnt <= '0;
        end else begin
            r_upc <= w_upc_next;
            if (w_retire)
                r_inst_cnt <= r_inst_cnt + CNT_ONE;
        end
    end

    // State-changing strobes are gated by rst_n so a reset mid-instruction
    // can never leave a write asserted for the rest of the cycle.
    assign PCWr     = rst_n && w_pcwr && !w_stall;
    assign IRWr     = rst_n && w_irwr && !w_stall;
    assign MemWr    = rst_n && w_memwr && !w_stall;
    assign PCWrCond = rst_n && w_pcwrcond;
    assign RegWr    = rst_n && w_regwr;
    assign IorD     = w_iord;
    assign MemRd    = w_memrd;
    assign MemtoReg = w_memtoreg;
    assign ALUSrcA  = w_alusrca;
    assign RegDst   = w_regdst;
    assign PCSrc    = w_pcsrc;
    assign ALUOp    = w_aluop;
    assign ALUSrcB  = w_alusrcb;
    assign upc      = r_upc;
    assign illegal  = rst_n && (r_upc == S_DECODE) && !w_op_ok;
    assign inst_cnt = r_inst_cnt;

endmodule

// File: tb/tb_micro_seq.sv
// Randomised bench for micro_seq: an instruction-path model predicts uPC,
// controls, illegal and both retire counters (CNT_W=32 and CNT_W=2) each cycle.
module tb_micro_seq;

    typedef struct packed {
        logic       pcwr, pcwrcond, iord, memrd, memwr, irwr, memtoreg, alusrca, regwr, regdst;
        logic [1:0] pcsrc, aluop, alusrcb;
    } ctrl_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       mem_rdy = 1'b1;
    logic [5:0] Op = 6'd0;

    logic        PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA, RegWr, RegDst;
    logic [1:0]  PCSrc, ALUOp, ALUSrcB;
    logic [3:0]  upc;
    logic        illegal;
    logic [31:0] inst_cnt;

    logic        b_PCWr, b_PCWrCond, b_IorD, b_MemRd, b_MemWr, b_IRWr, b_MemtoReg;
    logic        b_ALUSrcA, b_RegWr, b_RegDst;
    logic [1:0]  b_PCSrc, b_ALUOp, b_ALUSrcB;
    logic [3:0]  b_upc;
    logic        b_illegal;
    logic [1:0]  b_inst_cnt;

    micro_seq #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_rdy(mem_rdy),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
        .IRWr(IRWr), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWr(RegWr), .RegDst(RegDst),
        .PCSrc(PCSrc), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .upc(upc), .illegal(illegal),
        .inst_cnt(inst_cnt)
    );

    micro_seq #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_rdy(mem_rdy),
        .PCWr(b_PCWr), .PCWrCond(b_PCWrCond), .IorD(b_IorD), .MemRd(b_MemRd), .MemWr(b_MemWr),
        .IRWr(b_IRWr), .MemtoReg(b_MemtoReg), .ALUSrcA(b_ALUSrcA), .RegWr(b_RegWr),
        .RegDst(b_RegDst), .PCSrc(b_PCSrc), .ALUOp(b_ALUOp), .ALUSrcB(b_ALUSrcB),
        .upc(b_upc), .illegal(b_illegal), .inst_cnt(b_inst_cnt)
    );

    ctrl_t a_ctrl, b_ctrl;
    assign a_ctrl = {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA, RegWr, RegDst,
                     PCSrc, ALUOp, ALUSrcB};
    assign b_ctrl = {b_PCWr, b_PCWrCond, b_IorD, b_MemRd, b_MemWr, b_IRWr, b_MemtoReg,
                     b_ALUSrcA, b_RegWr, b_RegDst, b_PCSrc, b_ALUOp, b_ALUSrcB};

    int          n_vec = 0, n_cmp = 0, n_err = 0;
    int          m_state = 0;
    logic [31:0] m_cnt = 0;
    logic [3:0]  s_upc;
    ctrl_t       s_ctrl;
    logic        s_ill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // State walk of each instruction class, as listed in the microcode table.
    function automatic int path_len(input logic [5:0] op);
        case (op)
            OP_LW:                     return 5;
            OP_SW, OP_R, OP_ADDI:      return 4;
            OP_BEQ, OP_J:              return 3;
            default:                   return 2;
        endcase
    endfunction

    function automatic int path_at(input logic [5:0] op, input int k);
        int p[5];
        case (op)
            OP_LW:   p = '{0, 1, 2, 3, 4};
            OP_SW:   p = '{0, 1, 2, 5, 0};
            OP_R:    p = '{0, 1, 6, 7, 0};
            OP_ADDI: p = '{0, 1, 10, 11, 0};
            OP_BEQ:  p = '{0, 1, 8, 0, 0};
            OP_J:    p = '{0, 1, 9, 0, 0};
            default: p = '{0, 1, 0, 0, 0};
        endcase
        return p[k];
    endfunction

    function automatic ctrl_t spec_ctrl(input int st, input logic rdy, input logic rstn);
        ctrl_t c;
        c = '0;
        if (!rstn) begin
            c.memrd = 1'b1; c.alusrcb = 2'b01;
            return c;
        end
        case (st)
            0:  begin c.memrd = 1; c.irwr = 1; c.pcwr = 1; c.alusrcb = 2'b01; end
            1:  c.alusrcb = 2'b11;
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3:  begin c.memrd = 1; c.iord = 1; end
            4:  begin c.memtoreg = 1; c.regwr = 1; end
            5:  begin c.memwr = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            7:  begin c.regdst = 1; c.regwr = 1; end
            8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwrcond = 1; c.pcsrc = 2'b01; end
            9:  begin c.pcwr = 1; c.pcsrc = 2'b10; end
            10: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            11: c.regwr = 1;
            default: ;
        endcase
        if ((st == 0 || st == 3 || st == 5) && !rdy) begin
            c.pcwr = 0; c.irwr = 0; c.memwr = 0;
        end
        return c;
    endfunction

    task automatic compare_all();
        ctrl_t e;
        logic  e_ill;
        e     = spec_ctrl(m_state, mem_rdy, rst_n);
        e_ill = rst_n && (m_state == 1) && (path_len(Op) == 2);
        chk("ctrl", a_ctrl, e);
        chk("upc", upc, m_state);
        chk("illegal", illegal, e_ill);
        chk("inst_cnt", inst_cnt, m_cnt);
        chk("ctrl_w2", b_ctrl, e);
        chk("upc_w2", b_upc, m_state);
        chk("inst_cnt_w2", b_inst_cnt, m_cnt & 32'h3);
        s_upc = upc; s_ctrl = a_ctrl; s_ill = illegal;
    endtask

    task automatic model_advance();
        int n, nxt;
        logic found;
        if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_rdy) return;
        n = path_len(Op); nxt = 0; found = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (path_at(Op, k) == m_state) begin
                found = 1'b1;
                if (k == n - 1) begin
                    nxt = 0;
                    if (n > 2) m_cnt = m_cnt + 1;
                end else begin
                    nxt = path_at(Op, k + 1);
                end
            end
        end
        chk("model_path", {31'd0, found}, 32'd1);
        m_state = nxt;
    endtask

    task automatic cycle(input logic [5:0] op, input logic rdy);
        @(negedge clk);
        rst_n = 1'b1; Op = op; mem_rdy = rdy;
        #1 compare_all();
        @(posedge clk);
        model_advance();
        n_vec++;
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0; mem_rdy = 1'b1;
        m_state = 0; m_cnt = 0;
        #1 compare_all();
        n_vec++;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1 compare_all();
            n_vec++;
        end
    endtask

    initial begin
        int seq[5];
        logic [5:0] ops[6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

        // reset held with clock running
        apply_reset(3);
        chk("rst_upc", s_upc, 0);
        chk("rst_ctrl", s_ctrl, 32'h1001);
        chk("rst_cnt", inst_cnt, 0);

        // lw, no stalls
        for (int k = 0; k < 5; k++) begin
            cycle(OP_LW, 1'b1);
            seq[k] = s_upc;
            if (k == 4) chk("lw_wb_ctrl", s_ctrl, 32'h0280);
        end
        for (int k = 0; k < 5; k++) chk("lw_seq", seq[k], k);
        #1 chk("lw_cnt", inst_cnt, 1);

        // sw with three stall cycles in MEMWR
        for (int k = 0; k < 3; k++) cycle(OP_SW, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(OP_SW, 1'b0);
            chk("sw_hold_upc", s_upc, 5);
            chk("sw_hold_memwr", s_ctrl.memwr, 0);
        end
        cycle(OP_SW, 1'b1);
        chk("sw_go_memwr", s_ctrl.memwr, 1);
        #1 chk("sw_next_upc", upc, 0);

        // R-type, beq, j
        for (int k = 0; k < 4; k++) begin
            cycle(OP_R, 1'b1);
            if (k == 2) chk("rexec_ctrl", s_ctrl, 32'h0108);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(OP_BEQ, 1'b1);
            if (k == 2) chk("beq_ctrl", s_ctrl, 32'h4114);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(OP_J, 1'b1);
            if (k == 2) chk("jump_ctrl", s_ctrl, 32'h8020);
        end
        #1 chk("rbj_cnt", inst_cnt, 5);

        // illegal opcode
        cycle(6'b111111, 1'b1);
        chk("ill_fetch", s_ill, 0);
        cycle(6'b111111, 1'b1);
        chk("ill_decode", s_ill, 1);
        #1 chk("ill_next_upc", upc, 0);
        chk("ill_cnt", inst_cnt, 5);

        // fetch stall then addi
        for (int k = 0; k < 2; k++) begin
            cycle(OP_ADDI, 1'b0);
            chk("fstall_upc", s_upc, 0);
            chk("fstall_ctrl", s_ctrl, 32'h1001);
        end
        for (int k = 0; k < 4; k++) cycle(OP_ADDI, 1'b1);
        #1 chk("addi_cnt", inst_cnt, 6);

        // reset pulled in RWB
        for (int k = 0; k < 3; k++) cycle(OP_R, 1'b1);
        apply_reset(1);
        chk("midrst_regwr", s_ctrl.regwr, 0);
        chk("midrst_upc", s_upc, 0);

        // five addi from reset: 2-bit counter wraps to 1
        for (int k = 0; k < 20; k++) cycle(OP_ADDI, 1'b1);
        #1 chk("wrap_cnt_w2", b_inst_cnt, 1);
        chk("wrap_cnt_w32", inst_cnt, 5);

        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [5:0] op;
            op = Op;
            if ($urandom_range(0, 299) == 0) begin
                apply_reset($urandom_range(0, 2));
                op = Op;
            end
            if (m_state == 0) begin
                int r;
                r = $urandom_range(0, 7);
                op = (r < 6) ? ops[r] : 6'($urandom);
            end
            cycle(op, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
